frame_serializer: RTL and testbench
===================================

# frame_serializer

Parametrised frame serializer between the per-channel pixel FIFOs and the UART byte transmitter. Waits until every channel FIFO holds a pixel, pops one pixel from all channels at once, and sends the pixels as bytes over the `ldXmtDataReg`/`byteReady`/`tByte`/`txDone` handshake. Each frame can carry an optional sync header with a frame counter and an optional XOR checksum trailer. It generalises the fixed 4-channel, 16-bit, header-less sequencer to any channel count, pixel width and byte order.

## Interface
- `NUM_CHANNEL`, 4: number of pixel FIFOs; must be ≥1.
- `NUM_PIXEL`, 16: pixels per channel per frame; must be ≥1.
- `PIXEL_WIDTH`, 16: bits per pixel; must be a multiple of 8 and ≥8. `BPP = PIXEL_WIDTH/8`.
- `HEADER_EN`, 1: when 1, send bytes 0xA5, 0x5A, then `frameCount[7:0]` before the payload.
- `CHECKSUM_EN`, 1: when 1, send a trailer byte equal to the XOR of all payload bytes in the frame.
- `MSB_FIRST`, 0: 0 sends each pixel's low byte first; 1 sends the high byte first.
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `empty` in `NUM_CHANNEL`: FIFO empty flags.
- `rd` out 1: pop strobe, shared by all FIFOs.
- `fifoOut` in `NUM_CHANNEL`×`PIXEL_WIDTH`: FIFO data; valid the cycle after `rd`.
- `rcvReady` out 1: high in FRAME_INIT; enables the upstream pickers.
- `dataBus` out 8: byte presented to the transmitter.
- `ldXmtDataReg`, `byteReady`, `tByte` out 1 each: transmitter strobes, each one cycle wide.
- `txDone` in 1: transmitter idle / byte done (level).
- `busy` out 1: high in every state except FRAME_INIT.
- `frameDone` out 1: one-cycle pulse after the last byte of a frame completes.

## Operation
- States: FRAME_INIT, IDLE, LOAD, LD_XMT, BYTE_RDY, TBYTE, TX_WAIT. A phase register holds HDR, PAY or CHK.
- FRAME_INIT:
  - Clear `pixelCnt`, `byteIdx` and `chkAcc`; assert `rcvReady`.
  - When all channels are non-empty (`&~empty`): go to LD_XMT with phase HDR if `HEADER_EN`, otherwise go to IDLE with phase PAY.
- IDLE: when `&~empty`, assert `rd` for one cycle (combinational) and go to LOAD. If any channel is empty, wait.
- LOAD: capture all `fifoOut` into the pixel vector (`NUM_CHANNEL*BPP` bytes), set `byteIdx=0`, go to LD_XMT.
- Byte handshake, identical for every phase:
  - LD_XMT: `ldXmtDataReg=1`; `dataBus` is valid this cycle.
  - BYTE_RDY: `byteReady=1`.
  - TBYTE: `tByte=1`.
  - TX_WAIT: hold until `txDone`=1.
  - `dataBus` is registered and stays stable from LD_XMT until TX_WAIT exits.
- Byte order in PAY: channel 0 first. Within a channel, byte `k` of `BPP` is byte `k` when `MSB_FIRST=0` and byte `BPP-1-k` when `MSB_FIRST=1`.
- On leaving TX_WAIT:
  - HDR: after 3 bytes, go to IDLE with phase PAY.
  - PAY: XOR the byte into `chkAcc`.
    - `byteIdx < NUM_CHANNEL*BPP-1`: go to LD_XMT.
    - Else if `pixelCnt < NUM_PIXEL-1`: increment `pixelCnt`, go to IDLE.
    - Else if `CHECKSUM_EN`: go to LD_XMT with phase CHK; `dataBus=chkAcc`.
    - Else: end of frame.
  - CHK: end of frame.
- End of frame: pulse `frameDone`, increment `frameCount` (8 bits, wraps 0xFF→0x00), go to FRAME_INIT.

## Timing
- Reset values:
  - `rd`, strobes, `rcvReady`, `busy`, `frameDone` = 0.
  - `dataBus` = 0x00; state = FRAME_INIT; `frameCount` = 0.
  - `rcvReady` goes to 1 on the first cycle after reset is released.
- Reset asserted mid-frame: the frame is abandoned at once with no trailer, and `frameCount` is not incremented (it is reset).
- Cycle counts:
  - From `&~empty` in IDLE: `rd` in the same cycle, capture at +1, `ldXmtDataReg` at +2.
  - Per byte: 3 strobe cycles plus at least 1 TX_WAIT cycle.
  - `txDone` is sampled only in TX_WAIT. A `txDone` high during TBYTE is ignored.
- `rd` is never asserted unless all `empty` bits are 0. The block issues exactly one `rd` per pixel group, so it never underflows a FIFO.
- Counter widths are `$clog2` of their limits, and at least 1 bit.

## Structure
- Package `frame_serializer_pkg`:
  - state enum and phase enum;
  - `SYNC0=8'hA5`, `SYNC1=8'h5A`, `HDR_BYTES=3`.
- One sub-module, `byte_handshake`: runs the LD_XMT→BYTE_RDY→TBYTE→TX_WAIT sequence and returns a one-cycle `byteDone`. The top-level FSM selects the byte source and keeps the counters.

## Test plan
- Defaults, all FIFOs pre-filled with 16 pixels 0x0100+i:
  - 3 header bytes, then 128 payload bytes (LSB first, ch0..ch3), then the checksum (XOR of the payload).
  - Then `frameDone` and `frameCount=1`.
- `MSB_FIRST=1`, `PIXEL_WIDTH=24`, `NUM_CHANNEL=2`, pixel 0xABCDEF → bytes AB CD EF per channel.
- Channel 3 held empty while channels 0–2 are full → no `rd`, the block stays in IDLE/FRAME_INIT. Filling channel 3 → `rd` on the same cycle.
- `txDone` held low for 50 cycles after `tByte` → `dataBus` stable, no new strobe. `txDone` high during TBYTE is ignored.
- Reset pulsed in the middle of the payload → all outputs 0. The next frame starts with A5 5A 00.
- 256 frames with `HEADER_EN=1` → the frame counter byte wraps FF→00.

Source files
------------

// File: rtl/frame_serializer_pkg.sv
// frame_serializer_pkg: shared state/phase types and frame header constants
package frame_serializer_pkg;
  typedef enum logic [2:0] {FRAME_INIT, IDLE, LOAD, LD_XMT, BYTE_RDY, TBYTE, TX_WAIT} state_t;
  typedef enum logic [1:0] {HDR, PAY, CHK} phase_t;
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;
  localparam int HDR_BYTES = 3;
endpackage

// File: rtl/frame_serializer_if.sv
// frame_serializer_if: pixel FIFO side and UART transmitter side of the serializer
interface frame_serializer_if #(
  parameter int NUM_CHANNEL = 4,
  parameter int PIXEL_WIDTH = 16
);
  logic [NUM_CHANNEL-1:0] empty;
  logic rd;
  logic [NUM_CHANNEL*PIXEL_WIDTH-1:0] fifoOut;
  logic rcvReady;
  logic [7:0] dataBus;
  logic ldXmtDataReg;
  logic byteReady;
  logic tByte;
  logic txDone;
  logic busy;
  logic frameDone;
  modport master (
    input empty, fifoOut, txDone,
    output rd, rcvReady, dataBus, ldXmtDataReg, byteReady, tByte, busy, frameDone
  );
  modport slave (
    output empty, fifoOut, txDone,
    input rd, rcvReady, dataBus, ldXmtDataReg, byteReady, tByte, busy, frameDone
  );
endinterface

// File: rtl/frame_serializer_byte_handshake.sv
// byte_handshake: walks LD_XMT -> BYTE_RDY -> TBYTE -> TX_WAIT for one byte and flags completion
module byte_handshake
  import frame_serializer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic txDone,
  output logic ldXmtDataReg,
  output logic byteReady,
  output logic tByte,
  output logic byteDone
);
  state_t hs, hs_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) hs <= IDLE;
    else hs <= hs_n;
  // txDone only matters in TX_WAIT; a new start there chains straight into the next byte
  always_comb begin
    hs_n = start ? LD_XMT : IDLE;
    case (hs)
      LD_XMT:   hs_n = BYTE_RDY;
      BYTE_RDY: hs_n = TBYTE;
      TBYTE:    hs_n = TX_WAIT;
      TX_WAIT:  hs_n = txDone ? (start ? LD_XMT : IDLE) : TX_WAIT;
      default:  ;
    endcase
  end
  assign ldXmtDataReg = hs == LD_XMT;
  assign byteReady    = hs == BYTE_RDY;
  assign tByte        = hs == TBYTE;
  assign byteDone     = hs == TX_WAIT && txDone;
endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: pops one pixel per channel and streams header, payload and checksum bytes
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int NUM_CHANNEL = 4,
  parameter int NUM_PIXEL   = 16,
  parameter int PIXEL_WIDTH = 16,
  parameter bit HEADER_EN   = 1'b1,
  parameter bit CHECKSUM_EN = 1'b1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input logic clk,
  input logic reset,
  frame_serializer_if.master bus
);
  localparam int BPP = PIXEL_WIDTH / 8;
  localparam int NB  = NUM_CHANNEL * BPP;
  localparam int BW  = $clog2(NB > HDR_BYTES ? NB : HDR_BYTES);
  localparam int PW  = NUM_PIXEL > 1 ? $clog2(NUM_PIXEL) : 1;
  state_t state, state_n;
  phase_t phase, phase_n;
  logic [BW-1:0] byte_idx, byte_idx_n, idx_inc;
  logic [PW-1:0] pix_cnt, pix_cnt_n;
  logic [7:0] chk, chk_n, data, data_n, frame_cnt, frame_cnt_n, chk_pay;
  logic [NB*8-1:0] pay, pay_n, ord;
  logic all_full, start, byte_done, frame_end, frame_done;
  // payload bytes are reordered into transmit order once, at capture
  for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_c
    for (genvar k = 0; k < BPP; k++) begin : g_k
      assign ord[(c*BPP+k)*8 +: 8] = bus.fifoOut[c*PIXEL_WIDTH + (MSB_FIRST ? BPP-1-k : k)*8 +: 8];
    end
  end
  assign all_full      = &(~bus.empty);
  assign idx_inc       = byte_idx + BW'(1);
  assign chk_pay       = chk ^ data;
  assign bus.dataBus   = data;
  assign bus.busy      = state != FRAME_INIT;
  assign bus.rcvReady  = (state == FRAME_INIT) & ~reset;
  assign bus.frameDone = frame_done;
  byte_handshake u_hs (
    .clk(clk),
    .reset(reset),
    .start(start),
    .txDone(bus.txDone),
    .ldXmtDataReg(bus.ldXmtDataReg),
    .byteReady(bus.byteReady),
    .tByte(bus.tByte),
    .byteDone(byte_done)
  );
  // the top stays in LD_XMT while byte_handshake walks the four strobe/wait states
  always_comb begin
    state_n = state;
    phase_n = phase;
    byte_idx_n = byte_idx;
    pix_cnt_n = pix_cnt;
    chk_n = chk;
    data_n = data;
    frame_cnt_n = frame_cnt;
    pay_n = pay;
    start = 1'b0;
    frame_end = 1'b0;
    bus.rd = 1'b0;
    case (state)
      FRAME_INIT: begin
        byte_idx_n = '0;
        pix_cnt_n = '0;
        chk_n = '0;
        if (all_full) begin
          state_n = HEADER_EN ? LD_XMT : IDLE;
          phase_n = HEADER_EN ? HDR : PAY;
          start = HEADER_EN;
          data_n = HEADER_EN ? SYNC0 : data;
        end
      end
      IDLE: if (all_full) begin
        bus.rd = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        pay_n = ord;
        byte_idx_n = '0;
        data_n = ord[7:0];
        start = 1'b1;
        state_n = LD_XMT;
      end
      default: if (byte_done) begin
        if (phase == HDR) begin
          if (byte_idx == BW'(HDR_BYTES-1)) begin
            state_n = IDLE;
            phase_n = PAY;
          end else begin
            byte_idx_n = idx_inc;
            start = 1'b1;
            data_n = byte_idx == '0 ? SYNC1 : frame_cnt;
          end
        end else if (phase == PAY) begin
          chk_n = chk_pay;
          if (byte_idx != BW'(NB-1)) begin
            byte_idx_n = idx_inc;
            start = 1'b1;
            data_n = pay[{idx_inc, 3'b000} +: 8];
          end else if (pix_cnt != PW'(NUM_PIXEL-1)) begin
            pix_cnt_n = pix_cnt + PW'(1);
            state_n = IDLE;
          end else if (CHECKSUM_EN) begin
            phase_n = CHK;
            start = 1'b1;
            data_n = chk_pay;
          end else frame_end = 1'b1;
        end else frame_end = 1'b1;
      end
    endcase
    if (frame_end) begin
      frame_cnt_n = frame_cnt + 8'd1;
      state_n = FRAME_INIT;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FRAME_INIT;
      phase <= HDR;
      byte_idx <= '0;
      pix_cnt <= '0;
      chk <= '0;
      data <= '0;
      frame_cnt <= '0;
      pay <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      byte_idx <= byte_idx_n;
      pix_cnt <= pix_cnt_n;
      chk <= chk_n;
      data <= data_n;
      frame_cnt <= frame_cnt_n;
      pay <= pay_n;
      frame_done <= frame_end;
    end
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: scoreboard bench for a default serializer and a 2ch/24-bit/MSB-first one
module tb_frame_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  frame_serializer_if #(.NUM_CHANNEL(4), .PIXEL_WIDTH(16)) m_bus ();
  frame_serializer_if #(.NUM_CHANNEL(2), .PIXEL_WIDTH(24)) s_bus ();

  frame_serializer #(.NUM_CHANNEL(4), .NUM_PIXEL(16), .PIXEL_WIDTH(16),
    .HEADER_EN(1'b1), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b0)) u_m (.clk(clk), .reset(reset), .bus(m_bus));
  frame_serializer #(.NUM_CHANNEL(2), .NUM_PIXEL(1), .PIXEL_WIDTH(24),
    .HEADER_EN(1'b1), .CHECKSUM_EN(1'b1), .MSB_FIRST(1'b1)) u_s (.clk(clk), .reset(reset), .bus(s_bus));

  // main FIFO model: pushed[] owned by the stimulus, popped[] by the rd monitor
  int pushed [4];
  int popped [4];
  logic [15:0] m_out [4];
  logic [3:0] m_empty;
  logic m_tx = 1'b1;
  int rd_cnt = 0;
  bit rd_bad = 1'b0;
  logic [1:0] s_empty = 2'b11;
  logic [7:0] m_q [$];
  logic [7:0] s_q [$];

  function automatic logic [15:0] pixv(input int c, input int i);
    return 16'h0100 + 16'(i) + 16'(c) * 16'h1000;
  endfunction

  always_comb begin
    m_empty = '0;
    for (int c = 0; c < 4; c++) m_empty[c] = pushed[c] == popped[c];
  end
  assign m_bus.empty   = m_empty;
  assign m_bus.fifoOut = {m_out[3], m_out[2], m_out[1], m_out[0]};
  assign m_bus.txDone  = m_tx;
  assign s_bus.empty   = s_empty;
  assign s_bus.fifoOut = {24'h123456, 24'hABCDEF};
  assign s_bus.txDone  = 1'b1;

  always @(posedge clk) begin
    if (m_bus.rd) begin
      rd_cnt <= rd_cnt + 1;
      if (m_bus.empty !== 4'h0) rd_bad <= 1'b1;
      for (int c = 0; c < 4; c++) begin
        m_out[c] <= pixv(c, popped[c]);
        popped[c] <= popped[c] + 1;
      end
    end
  end

  task automatic push_main(input int base, input logic [7:0] fc);
    logic [7:0] x;
    logic [15:0] p;
    x = 8'h00;
    m_q.push_back(8'hA5);
    m_q.push_back(8'h5A);
    m_q.push_back(fc);
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 4; c++) begin
        p = pixv(c, base + i);
        m_q.push_back(p[7:0]);
        m_q.push_back(p[15:8]);
        x = x ^ p[7:0] ^ p[15:8];
      end
    m_q.push_back(x);
  endtask

  task automatic push_small(input logic [7:0] fc);
    s_q.push_back(8'hA5);
    s_q.push_back(8'h5A);
    s_q.push_back(fc);
    s_q.push_back(8'hAB);
    s_q.push_back(8'hCD);
    s_q.push_back(8'hEF);
    s_q.push_back(8'h12);
    s_q.push_back(8'h34);
    s_q.push_back(8'h56);
    s_q.push_back(8'hAB ^ 8'hCD ^ 8'hEF ^ 8'h12 ^ 8'h34 ^ 8'h56);
  endtask

  task automatic get_byte(input bit s, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = 8'hxx;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s ? s_bus.ldXmtDataReg : m_bus.ldXmtDataReg) begin
        ok = 1'b1;
        b = s ? s_bus.dataBus : m_bus.dataBus;
      end
    end
  endtask

  task automatic wait_frame_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m_bus.frameDone === 1'b1;
    end
    checks++;
    if (!ok || m_bus.rcvReady !== 1'b1) begin
      errors++;
      $display("FAIL frame_done: seen=%0b rcvReady=%b required seen=1 rcvReady=1", ok, m_bus.rcvReady);
    end
    @(negedge clk);
    checks++;
    if (m_bus.frameDone !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: frameDone=%b on 2nd cycle required 0", m_bus.frameDone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_bus.rd, m_bus.ldXmtDataReg, m_bus.byteReady, m_bus.tByte, m_bus.rcvReady,
         m_bus.busy, m_bus.frameDone, m_bus.dataBus} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b ld=%b br=%b tb=%b rcv=%b busy=%b fd=%b data=%h required all 0",
        m_bus.rd, m_bus.ldXmtDataReg, m_bus.byteReady, m_bus.tByte, m_bus.rcvReady,
        m_bus.busy, m_bus.frameDone, m_bus.dataBus);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_bus.rcvReady !== 1'b1 || m_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: rcvReady=%b busy=%b required 1 0", m_bus.rcvReady, m_bus.busy);
    end
  endtask

  task automatic test_frame();
    logic [7:0] b, e;
    bit ok;
    push_main(popped[0], 8'h00);
    for (int c = 0; c < 4; c++) pushed[c] += 16;
    for (int n = 0; n < 132; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL frame_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
      if (n == 0) begin
        checks++;
        if (m_bus.busy !== 1'b1 || m_bus.rcvReady !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_frame: busy=%b rcvReady=%b required 1 0", m_bus.busy, m_bus.rcvReady);
        end
      end
    end
    wait_frame_done();
  endtask

  task automatic test_empty_hold();
    logic [7:0] b, e;
    bit ok, bad;
    int r0;
    m_q.delete();
    push_main(popped[0], 8'h01);
    for (int c = 0; c < 3; c++) pushed[c] += 16;
    r0 = rd_cnt;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_bus.rcvReady !== 1'b1 || m_bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || rd_cnt != r0) begin
      errors++;
      $display("FAIL init_hold: left FRAME_INIT=%0b rd_count=%0d required 0 %0d", bad, rd_cnt, r0);
    end
    pushed[3] += 1;
    for (int n = 0; n < 11; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL hold_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (m_bus.ldXmtDataReg !== 1'b0 || m_bus.rd !== 1'b0 || m_bus.busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || rd_cnt != r0 + 1) begin
      errors++;
      $display("FAIL idle_hold: activity=%0b rd_count=%0d required 0 %0d", bad, rd_cnt, r0 + 1);
    end
    pushed[3] += 15;
    #1;
    checks++;
    if (m_bus.rd !== 1'b1) begin
      errors++;
      $display("FAIL rd_same_cycle: rd=%b required 1", m_bus.rd);
    end
    repeat (2) @(negedge clk);
    e = m_q.pop_front();
    checks++;
    if (m_bus.ldXmtDataReg !== 1'b1 || m_bus.dataBus !== e) begin
      errors++;
      $display("FAIL ld_latency: ld=%b data=%h required 1 %h", m_bus.ldXmtDataReg, m_bus.dataBus, e);
    end
    for (int n = 0; n < 120; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL resume_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    wait_frame_done();
    checks++;
    if (rd_bad) begin
      errors++;
      $display("FAIL underflow: rd seen with an empty FIFO, required never");
    end
  endtask

  task automatic test_tx_stall();
    logic [7:0] b, e, hold;
    bit ok, bad;
    m_q.delete();
    push_main(popped[0], 8'h02);
    for (int c = 0; c < 4; c++) pushed[c] += 16;
    for (int n = 0; n < 5; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL stall_pre_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = m_bus.tByte === 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tbyte_seen: tByte not observed, required within 10 cycles");
    end
    hold = m_bus.dataBus;
    m_tx = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (m_bus.ldXmtDataReg || m_bus.byteReady || m_bus.tByte || m_bus.dataBus !== hold) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL tx_wait_hold: strobe or dataBus=%h change, required quiet with %h", m_bus.dataBus, hold);
    end
    m_tx = 1'b1;
    for (int n = 0; n < 127; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL stall_post_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    wait_frame_done();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, e;
    bit ok;
    m_q.delete();
    push_main(popped[0], 8'h03);
    for (int c = 0; c < 4; c++) pushed[c] += 16;
    for (int n = 0; n < 20; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL pre_reset_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({m_bus.rd, m_bus.ldXmtDataReg, m_bus.byteReady, m_bus.tByte, m_bus.rcvReady,
         m_bus.busy, m_bus.frameDone, m_bus.dataBus} !== 15'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b rcv=%b data=%h ld=%b required all 0",
        m_bus.busy, m_bus.rcvReady, m_bus.dataBus, m_bus.ldXmtDataReg);
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) pushed[c] = popped[c];
    m_q.delete();
    reset = 1'b0;
    push_main(popped[0], 8'h00);
    for (int c = 0; c < 4; c++) pushed[c] += 16;
    for (int n = 0; n < 132; n++) begin
      get_byte(1'b0, b, ok);
      e = m_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL post_reset_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
    wait_frame_done();
  endtask

  task automatic test_msb_first();
    logic [7:0] b, e;
    bit ok;
    push_small(8'h00);
    s_empty = 2'b00;
    for (int n = 0; n < 10; n++) begin
      get_byte(1'b1, b, ok);
      e = s_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        errors++;
        $display("FAIL msb_byte %0d: got %h (seen=%0b) required %h", n, b, ok, e);
        if (!ok) break;
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] b, e;
    bit ok;
    ok = 1'b1;
    for (int f = 1; f <= 256 && ok; f++) begin
      push_small(8'(f));
      for (int n = 0; n < 10; n++) begin
        get_byte(1'b1, b, ok);
        e = s_q.pop_front();
        checks++;
        if (!ok || b !== e) begin
          errors++;
          $display("FAIL wrap_frame %0d byte %0d: got %h (seen=%0b) required %h", f, n, b, ok, e);
          if (!ok) break;
        end
      end
    end
    s_empty = 2'b11;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_empty_hold();
    test_tx_stall();
    test_reset_mid();
    test_msb_first();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
